// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial WIDTH-bit adder, one full_adder bit per clock,
//                LSB first, with start/busy/done handshake.
//                Optional SERIAL_ADDER_SUB_EN adds a Sub port (A - B).
//  Revision    : 1.0 - initial release
// ============================================================================

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               load;
    logic               sub_op;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               fa_s;
    logic               fa_c;
    logic [WIDTH-1:0]   res_next;
    logic               last_bit;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_op = Sub;
`else
    assign sub_op = 1'b0;
`endif

    assign last_bit = (cnt == LAST_BIT);

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1, so the carry seed is forced high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else if (load) begin
            a_sr  <= A;
            b_sr  <= sub_op ? ~B : B;
            carry <= sub_op | Cin;
            cnt   <= '0;
        end else if (busy) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            carry <= fa_c;
            cnt   <= cnt + CNT_W'(1);
            if (last_bit) begin
                Sum  <= res_next;
                Cout <= fa_c;
            end
        end
    end

    // Only the WIDTH-1 already-computed bits need storage; the current
    // sum bit is merged in combinationally so completion needs no extra edge.
    if (WIDTH > 1) begin : g_res_multi
        logic [WIDTH-2:0] res_sr;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_sr <= '0;
            end else if (load) begin
                res_sr <= '0;
            end else if (busy) begin
                res_sr <= res_next[WIDTH-1:1];
            end
        end

        assign res_next = {fa_s, res_sr};
    end else begin : g_res_single
        assign res_next = fa_s;
    end

endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder (WIDTH=8) using an
//                arithmetic reference model and directed + random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Cout;

    int vectors = 0;
    int errors  = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic cin, input logic s);
`ifdef SERIAL_ADDER_SUB_EN
        if (s) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
`endif
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    // Reference: an accepted operation occupies W cycles, then publishes its result.
    int           m_remain = 0;
    logic         m_done   = 1'b0;
    logic [W-1:0] m_sum    = '0;
    logic         m_cout   = 1'b0;
    logic [W:0]   m_pend   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_remain <= 0;
            m_done   <= 1'b0;
            m_sum    <= '0;
            m_cout   <= 1'b0;
        end else if (m_remain == 0) begin
            m_done <= 1'b0;
            if (start) begin
                m_pend   <= model_result(A, B, Cin, sub);
                m_remain <= W;
            end
        end else begin
            m_remain <= m_remain - 1;
            if (m_remain == 1) begin
                {m_cout, m_sum} <= m_pend;
                m_done          <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        vectors++;
        if ({busy, done, Sum, Cout} !== {(m_remain != 0), m_done, m_sum, m_cout}) begin
            errors++;
            $display("FAIL cycle_compare t=%0t: busy=%b done=%b Sum=0x%0h Cout=%b, required busy=%b done=%b Sum=0x%0h Cout=%b",
                     $time, busy, done, Sum, Cout, (m_remain != 0), m_done, m_sum, m_cout);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic s, input logic [W-1:0] exp_sum, input logic exp_cout,
                          input logic [W-1:0] hold, input logic inject);
        int k;
        int bc;
        @(negedge clk);
        A = a; B = b; Cin = cin; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k  = 1;
        bc = busy ? 1 : 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
            start = inject && (k == 3);
            if (start) begin
                A = a ^ 8'h5A;
                B = b ^ 8'hC3;
            end
            if (busy) bc++;
            if (k == 5) check("sum_hold", 32'(Sum), 32'(hold));
        end
        check("latency", k, W + 1);
        check("busy_cycles", bc, W);
        check("sum", 32'(Sum), 32'(exp_sum));
        check("cout", 32'(Cout), 32'(exp_cout));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        int npulses;
        int k;
        rst_n = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_sum", 32'(Sum), 0);
        check("reset_cout", 32'(Cout), 0);
        rst_n = 1'b1;

        run_op(8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 8'h00, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 8'h7F, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h00, 1'b0);
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 8'hFF, 1'b1);

        // start held high: a result every W+1 cycles with no idle gap
        @(negedge clk);
        A = 8'h12; B = 8'h34; Cin = 1'b1; sub = 1'b0; start = 1'b1;
        last = -1;
        npulses = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                check("b2b_sum", 32'(Sum), 32'h47);
                if (last >= 0) check("b2b_spacing", i - last, W + 1);
                last = i;
                npulses++;
            end
        end
        check("b2b_pulses", npulses, 4);
        start = 1'b0;
        k = 0;
        while ((busy || done) && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("b2b_drain", 32'(k < 30), 1);

        // asynchronous reset after three SHIFT edges
        @(negedge clk);
        A = 8'h35; B = 8'h4A; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_sum", 32'(Sum), 0);
        check("arst_cout", 32'(Cout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 8'h00, 1'b0);
        run_op(8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 8'h02, 1'b0);
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 8'h7F, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 8'h02, 1'b0);
        run_op(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h0F, 1'b0);
`endif

        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) != 0);
            A     = W'($urandom);
            B     = W'($urandom);
            Cin   = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sub   = 1'($urandom);
`endif
        end
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
